// File: rtl/rtc_pkg.sv
// Shared constants, time payload and BCD helper for the RTC seven-segment display path.
package rtc_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int unsigned MIN_W      = 2;
    localparam int unsigned SEC_W      = 6;
    localparam int unsigned SEG_W      = 7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } rtc_time_t;

    // Tens digit of a 0..63 seconds value by compare ladder
    function automatic logic [2:0] sec_tens(input logic [SEC_W-1:0] sec);
        if (sec >= 6'd60)      return 3'd6;
        else if (sec >= 6'd50) return 3'd5;
        else if (sec >= 6'd40) return 3'd4;
        else if (sec >= 6'd30) return 3'd3;
        else if (sec >= 6'd20) return 3'd2;
        else if (sec >= 6'd10) return 3'd1;
        else                   return 3'd0;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Decimal digit to active-low seven-segment pattern; blank or out-of-range values turn all segments off.
module seg7_encode
    import rtc_pkg::*;
(
    input  logic [3:0]       val,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (val)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/rtc_display_mux.sv
// Multiplexed M.SS display of the RTC counter: input sync, per-frame snapshot,
// BCD split, digit scan and blink once the run is done.
module rtc_display_mux
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MIN_W-1:0] min,
    input  logic [SEC_W-1:0] sec_counter,
    input  logic             done,
    output logic [3:0]       an,
    output logic [SEG_W-1:0] seg,
    output logic             dp
);

    localparam int unsigned REF_W   = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    rtc_time_t            meta_q, meta_d, sync_q, sync_d, snap_q, snap_d;
    logic                 done_meta_q, done_meta_d, done_sync_q, done_sync_d;
    logic [REF_W-1:0]     ref_cnt_q, ref_cnt_d;
    logic [DIGIT_W-1:0]   digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_ph_q, blink_ph_d;
    logic [3:0]           an_q, an_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic                 ref_wrap, blink_wrap;
    logic [2:0]           sec_tens_dig;
    logic [3:0]           sec_ones_dig;
    logic [3:0]           digit_val;
    logic                 digit_blank;
    logic                 digit_dp;
    logic [SEG_W-1:0]     seg_c;

    // Digit selection and BCD split of the frozen frame
    always_comb begin
        sec_tens_dig = sec_tens(snap_q.sec);
        sec_ones_dig = 4'(snap_q.sec - SEC_W'(sec_tens_dig) * SEC_W'(10));
        digit_val    = 4'd0;
        digit_blank  = 1'b0;
        digit_dp     = 1'b1;
        case (digit_idx_q)
            DIGIT_W'(0): digit_val = sec_ones_dig;
            DIGIT_W'(1): digit_val = 4'(sec_tens_dig);
            DIGIT_W'(2): begin
                digit_val = 4'(snap_q.min);
                digit_dp  = 1'b0;
            end
            default:     digit_blank = 1'b1;
        endcase
    end

    seg7_encode u_seg7_encode (
        .val   (digit_val),
        .blank (digit_blank),
        .seg_c (seg_c)
    );

    always_comb begin
        meta_d      = meta_q;
        sync_d      = sync_q;
        snap_d      = snap_q;
        done_meta_d = done_meta_q;
        done_sync_d = done_sync_q;
        ref_cnt_d   = ref_cnt_q;
        digit_idx_d = digit_idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;

        meta_d.min  = min;
        meta_d.sec  = sec_counter;
        sync_d      = meta_q;
        done_meta_d = done;
        done_sync_d = done_meta_q;

        ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : REF_W'(ref_cnt_q + 1'b1);
        if (ref_wrap) begin
            digit_idx_d = DIGIT_W'(digit_idx_q + 1'b1);
            // Load on the 3->0 wrap so a whole scan shows one time value
            if (digit_idx_q == DIGIT_W'(NUM_DIGITS - 1)) begin
                snap_d = sync_q;
            end
        end

        blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        if (done_sync_q) begin
            blink_cnt_d = blink_wrap ? '0 : BLINK_W'(blink_cnt_q + 1'b1);
            if (blink_wrap) begin
                blink_ph_d = ~blink_ph_q;
            end
        end else begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end

        an_d  = (digit_blank || blink_ph_q) ? 4'hF : ~(4'b0001 << digit_idx_q);
        seg_d = seg_c;
        dp_d  = digit_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= '0;
            sync_q      <= '0;
            snap_q      <= '0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            ref_cnt_q   <= '0;
            digit_idx_q <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            an_q        <= 4'hF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            snap_q      <= snap_d;
            done_meta_q <= done_meta_d;
            done_sync_q <= done_sync_d;
            ref_cnt_q   <= ref_cnt_d;
            digit_idx_q <= digit_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_rtc_display_mux.sv
// Directed bench for rtc_display_mux with short refresh and blink periods.
module tb_rtc_display_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] min;
    logic [5:0] sec_counter;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_display_mux #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .min         (min),
        .sec_counter (sec_counter),
        .done        (done),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_disp(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp);
        check_eq({tag, ".an"},  32'(an),  32'(e_an));
        check_eq({tag, ".seg"}, 32'(seg), 32'(e_seg));
        check_eq({tag, ".dp"},  32'(dp),  32'(e_dp));
    endtask

    // Advance n rising edges, then park on the falling edge for sampling/driving
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        min         = 2'd2;
        sec_counter = 6'd45;
        done        = 1'b0;

        tick(3);
        check_disp("reset", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;

        // First frame shows the reset snapshot 0.00
        tick(1);  check_disp("f0_d0", 4'hE, 7'h40, 1'b1);
        tick(4);  check_disp("f0_d1", 4'hD, 7'h40, 1'b1);
        tick(4);  check_disp("f0_d2", 4'hB, 7'h40, 1'b0);
        tick(4);  check_disp("f0_d3", 4'hF, 7'h7F, 1'b1);
        // Second frame shows 2.45
        tick(4);  check_disp("f1_d0", 4'hE, 7'h12, 1'b1);
        tick(4);  check_disp("f1_d1", 4'hD, 7'h19, 1'b1);
        tick(4);  check_disp("f1_d2", 4'hB, 7'h24, 1'b0);
        tick(4);  check_disp("f1_d3", 4'hF, 7'h7F, 1'b1);

        // Upper boundary 3.60
        sec_counter = 6'd60; min = 2'd3;
        tick(4);  check_disp("s60_d0", 4'hE, 7'h40, 1'b1);
        tick(4);  check_disp("s60_d1", 4'hD, 7'h02, 1'b1);
        tick(4);  check_disp("s60_d2", 4'hB, 7'h30, 1'b0);

        // 12 then 13 arriving mid-frame
        sec_counter = 6'd12;
        tick(8);  check_disp("s12_d0", 4'hE, 7'h24, 1'b1);
        tick(4);  check_disp("s12_d1", 4'hD, 7'h79, 1'b1);
        sec_counter = 6'd13;
        tick(4);  check_disp("s12_d2", 4'hB, 7'h30, 1'b0);
        tick(8);  check_disp("s13_d0", 4'hE, 7'h30, 1'b1);

        // Change both digits while digit 0 is lit; tens must hold until the next frame
        sec_counter = 6'd27;
        tick(4);  check_disp("hold_d1", 4'hD, 7'h79, 1'b1);
        tick(12); check_disp("s27_d0", 4'hE, 7'h78, 1'b1);
        tick(4);  check_disp("s27_d1", 4'hD, 7'h24, 1'b1);

        // Blink: 8 cycles scanning, 8 cycles dark, alternating
        done = 1'b1;
        tick(7);  check_eq("blink_pre.an", 32'(an), 32'hB);
        tick(5);  check_eq("blink_off0.an", 32'(an), 32'hF);
        tick(6);  check_eq("blink_off1.an", 32'(an), 32'hF);
        tick(1);  check_disp("blink_on0", 4'hD, 7'h24, 1'b1);
        tick(1);  check_eq("blink_on1.an", 32'(an), 32'hB);
        tick(8);  check_eq("blink_off2.an", 32'(an), 32'hF);
        done = 1'b0;
        tick(3);  check_eq("undone_lag.an", 32'(an), 32'hF);
        tick(1);  check_disp("undone_d1", 4'hD, 7'h24, 1'b1);
        tick(4);  check_disp("undone_d2", 4'hB, 7'h30, 1'b0);

        // Reset in the middle of digit 2
        rst = 1'b1;
        tick(1);  check_disp("midrst", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        tick(1);  check_disp("post_d0", 4'hE, 7'h40, 1'b1);
        tick(4);  check_disp("post_d1", 4'hD, 7'h40, 1'b1);
        tick(12); check_disp("post_f1_d0", 4'hE, 7'h78, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
